// File: rtl/tinycpu_monitor.sv
// tinycpu_monitor: buffers a register snapshot per fetch in a trace FIFO and
// raises a sticky halt on the self-jump idiom or a fetch-count watchdog.
module tinycpu_monitor #(
   parameter int DW          = 8,
   parameter int STW         = 3,
   parameter int FETCH_STATE = 0,
   parameter int EXEC_STATE  = 2,
   parameter int DEPTH       = 8,
   parameter int LOOP_HITS   = 2,
   parameter int WDW         = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [STW-1:0]             state,
   input  logic [1:0]                 opcode,
   input  logic [DW-1:0]              rA,
   input  logic [DW-1:0]              rB,
   input  logic [DW-1:0]              rM,
   input  logic [DW-1:0]              rP,
   input  logic [WDW-1:0]             wdog_limit,
   input  logic                       trace_rd,
   output logic                       trace_valid,
   output logic [4*DW-1:0]            trace_data,
   output logic [$clog2(DEPTH):0]     trace_count,
   output logic                       overflow,
   output logic [WDW-1:0]             fetch_count,
   output logic                       halt,
   output logic [1:0]                 halt_cause
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int LW = $clog2(LOOP_HITS + 1);

   logic [4*DW-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [LW-1:0]   loop_cnt;
   logic [CW-1:0]   cnt_nxt;
   logic [WDW-1:0]  fc_next;
   logic [4*DW-1:0] din;
   logic            s, fetch_ev, exec_ev, pop, full, push, hit;

   assign s        = enable & ~halt;
   assign fetch_ev = s && state == STW'(FETCH_STATE);
   assign exec_ev  = s && state == STW'(EXEC_STATE);
   assign pop      = trace_rd & trace_valid;
   assign full     = trace_count == CW'(DEPTH);
   assign push     = fetch_ev & (~full | pop);
   assign hit      = opcode == 2'b11 && rP - DW'(1) == rM;
   assign fc_next  = fetch_count + WDW'(1);
   assign din      = {rA, rB, rM, rP};
   assign cnt_nxt  = trace_count + CW'(push) - CW'(pop);

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         trace_count <= '0;
         trace_valid <= 1'b0;
         trace_data  <= '0;
         overflow    <= 1'b0;
         fetch_count <= '0;
         loop_cnt    <= '0;
         halt        <= 1'b0;
         halt_cause  <= 2'b00;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         trace_count <= cnt_nxt;
         trace_valid <= cnt_nxt != '0;
         if (fetch_ev & full & ~pop) overflow <= 1'b1;
         // Keep the head entry registered so the output is first-word fall-through
         if (pop)
            trace_data <= trace_count > CW'(1) ? mem[rd_ptr + AW'(1)] : push ? din : '0;
         else if (trace_count == '0 && push)
            trace_data <= din;
         if (fetch_ev) begin
            fetch_count <= fc_next;
            if (wdog_limit != '0 && fc_next == wdog_limit) begin
               halt       <= 1'b1;
               halt_cause <= 2'b10;
            end
         end
         if (exec_ev) begin
            loop_cnt <= hit ? loop_cnt + LW'(1) : '0;
            if (hit && loop_cnt == LW'(LOOP_HITS - 1)) begin
               halt       <= 1'b1;
               halt_cause <= 2'b01;
            end
         end
      end
   end
endmodule

// File: tb/tb_tinycpu_monitor.sv
// tb_tinycpu_monitor: randomized and directed stimulus against a queue-based
// behavioural model of the monitor, compared every cycle.
module tb_tinycpu_monitor;
   localparam int DW = 8, STW = 3, FS = 0, ES = 2, DEPTH = 8, LH = 2, WDW = 16;

   logic           clk = 0, reset = 1, enable = 0, trace_rd = 0;
   logic [STW-1:0] state = 3'd1;
   logic [1:0]     opcode = 0;
   logic [DW-1:0]  rA = 0, rB = 0, rM = 0, rP = 0;
   logic [WDW-1:0] wdog_limit = 0;
   logic           trace_valid, overflow, halt;
   logic [4*DW-1:0] trace_data;
   logic [3:0]     trace_count;
   logic [WDW-1:0] fetch_count;
   logic [1:0]     halt_cause;

   tinycpu_monitor #(.DW(DW), .STW(STW), .FETCH_STATE(FS), .EXEC_STATE(ES), .DEPTH(DEPTH),
                     .LOOP_HITS(LH), .WDW(WDW)) dut (
      .clk(clk), .reset(reset), .enable(enable), .state(state), .opcode(opcode),
      .rA(rA), .rB(rB), .rM(rM), .rP(rP), .wdog_limit(wdog_limit), .trace_rd(trace_rd),
      .trace_valid(trace_valid), .trace_data(trace_data), .trace_count(trace_count),
      .overflow(overflow), .fetch_count(fetch_count), .halt(halt), .halt_cause(halt_cause));

   always #5 clk = ~clk;

   int compared = 0, mismatched = 0;
   bit chk = 0;
   logic [31:0] q[$];
   bit   m_ovf, m_halt;
   int   m_fc, m_hits, m_cause;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      q.delete();
      m_ovf = 0; m_halt = 0; m_fc = 0; m_hits = 0; m_cause = 0;
   endtask

   // Model of one clock edge, from the rules in plain queue/integer arithmetic
   task automatic m_update();
      bit s, fe, ee, pop;
      int sz;
      if (!reset) begin
         m_reset();
         return;
      end
      s  = enable && !m_halt;
      fe = s && int'(state) == FS;
      ee = s && int'(state) == ES;
      sz = q.size();
      pop = trace_rd && sz > 0;
      if (pop) void'(q.pop_front());
      if (fe) begin
         if (sz < DEPTH || pop) q.push_back({rA, rB, rM, rP});
         else m_ovf = 1;
         m_fc = (m_fc + 1) % 65536;
         if (wdog_limit != 0 && m_fc == int'(wdog_limit)) begin m_halt = 1; m_cause = 2; end
      end
      if (ee) begin
         if (opcode == 2'b11 && (int'(rP) + 255) % 256 == int'(rM)) begin
            m_hits++;
            if (m_hits >= LH) begin m_halt = 1; m_cause = 1; end
         end else m_hits = 0;
      end
   endtask

   always @(negedge clk) if (chk) begin
      check("valid", trace_valid, q.size() != 0);
      check("count", trace_count, q.size());
      check("overflow", overflow, m_ovf);
      check("fetch_count", fetch_count, m_fc);
      check("halt", halt, m_halt);
      check("halt_cause", halt_cause, m_cause);
      if (q.size() != 0) check("data", trace_data, q[0]);
   end

   task automatic set(input bit en, input int st, input int op, input logic [31:0] r, input bit rd);
      enable = en; state = 3'(st); opcode = 2'(op); {rA, rB, rM, rP} = r; trace_rd = rd;
   endtask

   task automatic step();
      @(posedge clk);
      m_update();
      @(negedge clk);
   endtask

   task automatic fetch(input logic [31:0] r);
      set(1, FS, 0, r, 0); step();
   endtask

   task automatic exec(input logic [7:0] m, input logic [7:0] p);
      set(1, ES, 3, {16'h0, m, p}, 0); step();
   endtask

   task automatic pop1();
      set(1, 1, 0, 0, 1); step();
   endtask

   task automatic do_reset();
      #2 reset = 0;
      m_reset();
      @(negedge clk);
      #2 reset = 1;
      set(1, 1, 0, 0, 0);
   endtask

   logic [7:0] p, m;

   initial begin
      #2 reset = 0;
      m_reset();
      #1;
      check("rst_valid", trace_valid, 0);
      check("rst_data", trace_data, 0);
      check("rst_count", trace_count, 0);
      check("rst_halt", {halt, halt_cause, overflow}, 0);
      check("rst_fc", fetch_count, 0);
      @(negedge clk);
      chk = 1;
      #2 reset = 1;
      set(1, 1, 0, 0, 0);

      fetch(32'h01020304); fetch(32'h05060708); fetch(32'h090A0B0C);
      set(1, 1, 0, 0, 0); step();
      check("t1_count3", trace_count, 3);
      check("t1_head1", trace_data, 32'h01020304);
      pop1(); check("t1_head2", trace_data, 32'h05060708);
      pop1(); check("t1_head3", trace_data, 32'h090A0B0C);
      check("t1_count1", trace_count, 1);
      pop1(); check("t1_empty", {trace_valid, trace_count}, 0);
      pop1(); check("t1_pop_empty", trace_count, 0);

      do_reset();
      for (int i = 1; i <= 9; i++) fetch(32'(i));
      check("t2_full", trace_count, 8);
      check("t2_ovf", overflow, 1);
      check("t2_head", trace_data, 1);
      do_reset();
      for (int i = 1; i <= 8; i++) fetch(32'(i));
      set(1, FS, 0, 32'h99, 1); step();
      check("t2_pp_count", trace_count, 8);
      check("t2_pp_ovf", overflow, 0);
      check("t2_pp_head", trace_data, 2);

      do_reset();
      exec(8'h0F, 8'h10); exec(8'h0F, 8'h10);
      check("t3_loop", {halt, halt_cause}, 3'b101);
      do_reset();
      exec(8'h0F, 8'h10); exec(8'h00, 8'h10); exec(8'h0F, 8'h10);
      check("t3_hmh", halt, 0);
      exec(8'h0F, 8'h10);
      check("t3_hh", halt, 1);
      do_reset();
      exec(8'hFF, 8'h00); exec(8'hFF, 8'h00);
      check("t3_wrap", {halt, halt_cause}, 3'b101);

      do_reset();
      wdog_limit = 5;
      for (int i = 0; i < 4; i++) fetch(32'(i));
      check("t4_nohalt", halt, 0);
      fetch(32'h4);
      check("t4_wdog", {halt, halt_cause}, 3'b110);
      check("t4_fc", fetch_count, 5);
      for (int i = 0; i < 3; i++) fetch(32'hAA);
      check("t4_frozen", {fetch_count, 4'(trace_count)}, {16'd5, 4'd5});
      for (int i = 0; i < 5; i++) pop1();
      check("t4_drain", trace_count, 0);
      wdog_limit = 0;

      do_reset();
      for (int i = 0; i < 3; i++) begin set(0, FS, 0, 32'h55, 0); step(); end
      check("t5_disabled", {fetch_count, 4'(trace_count)}, 0);

      do_reset();
      for (int i = 0; i < 4; i++) fetch(32'(i + 16));
      exec(8'h0F, 8'h10); exec(8'h0F, 8'h10);
      check("t6_pre", {halt, 4'(trace_count)}, {1'b1, 4'd4});
      #2 reset = 0;
      m_reset();
      #1;
      check("t6_async", {trace_valid, trace_data, trace_count, overflow, fetch_count, halt, halt_cause}, 0);
      @(negedge clk);
      #2 reset = 1;
      fetch(32'hDEADBEEF);
      check("t6_after", trace_count, 1);
      check("t6_data", trace_data, 32'hDEADBEEF);

      do_reset();
      set(1, FS, 0, 32'h12345678, 0);
      repeat (70000) step();
      check("t7_wrap", fetch_count, 4464);
      check("t7_nohalt", halt, 0);

      do_reset();
      repeat (3000) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
            wdog_limit = $urandom_range(0, 1) ? 16'($urandom_range(1, 40)) : 16'd0;
         end
         p = 8'($urandom);
         m = $urandom_range(0, 1) ? p - 8'd1 : 8'($urandom);
         set($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             {8'($urandom), 8'($urandom), m, p}, $urandom_range(0, 3) == 0);
         step();
      end
      chk = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/tinycpu_monitor.md
# tinycpu_monitor

Synthesisable run-time monitor for the tinycpu core, replacing bench-only loop detection and register printing with hardware usable in both the behavioural and structural builds. It samples the CPU control state and architectural registers (A, B, M, P) and buffers a register snapshot per instruction fetch in a trace FIFO. It detects the self-jump halt idiom and a fetch-count watchdog, raising a sticky `halt` with a cause code. It sits beside the CPU in the simulation/FPGA top level, read out by a bench or debug port through a pop handshake.

## Interface
- `DW`, 8: register width of A/B/M/P.
- `STW`, 3: width of the CPU control-state bus.
- `FETCH_STATE`, 0: state value at which a snapshot is taken; must differ from `EXEC_STATE`.
- `EXEC_STATE`, 2: state value at which the jump opcode is evaluated.
- `DEPTH`, 8: trace FIFO entries; power of two, ≥2.
- `LOOP_HITS`, 2: consecutive self-jump detections required to halt; ≥1.
- `WDW`, 16: fetch/watchdog counter width.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: monitor active; 0 freezes capture, detection and counters.
- `state` in STW: CPU control state.
- `opcode` in 2: CPU instruction bits [7:6].
- `rA`, `rB`, `rM`, `rP` in DW each: CPU register values.
- `wdog_limit` in WDW: fetch budget; 0 disables watchdog.
- `trace_rd` in 1: pop request.
- `trace_valid` out 1: FIFO non-empty.
- `trace_data` out 4*DW: head entry {A,B,M,P}, A in MSBs; first-word fall-through.
- `trace_count` out log2(DEPTH)+1: occupancy.
- `overflow` out 1: sticky; a snapshot was dropped.
- `fetch_count` out WDW: fetches sampled since reset, wraps.
- `halt` out 1: sticky halt.
- `halt_cause` out 2: 00 none, 01 self-loop, 10 watchdog.

## Operation
- Sample qualifier `s = enable & ~halt`.
- Fetch event: `s & state==FETCH_STATE`. Pushes {rA,rB,rM,rP}; increments `fetch_count` modulo 2^WDW.
- Push when full: entry dropped, `overflow` set, unless a pop occurs in the same cycle, in which case the push is accepted and occupancy is unchanged.
- Pop: `trace_rd & trace_valid`. Pop while empty is ignored. Pop and push while empty: push accepted, `trace_count` becomes 1.
- Pops are honoured regardless of `enable` and `halt`.
- Loop check at `s & state==EXEC_STATE`: hit when `opcode==2'b11` and `(rP - 1) mod 2^DW == rM`. P=0 with M=all-ones is a hit.
  - Hit increments the loop counter; a non-hit clears it.
  - Reaching `LOOP_HITS` sets `halt`, cause 01.
- Watchdog: when `wdog_limit != 0` and a fetch event makes the new `fetch_count == wdog_limit`, set `halt`, cause 10.
- Fetch and exec events are mutually exclusive, so the two causes never coincide. `halt_cause` latches with `halt` and holds until reset.
- After halt: no captures, no counting, loop counter frozen; FIFO remains readable.

## Timing
- All outputs registered; all are 0 after reset (`trace_data` 0, FIFO empty).
- Snapshot visible on `trace_data`/`trace_valid` one cycle after the fetch-event edge when the FIFO was empty.
- `halt` asserts on the edge that samples the triggering condition, visible the following cycle.
- `trace_count`/`overflow` update on the same edge as push/pop.
- Reset mid-operation clears FIFO, counters, `halt` and `overflow` immediately; no partial state survives.

## Test plan
- Three fetches with A,B,M,P = 01,02,03,04 / 05,.. / 09,..; then pop ×3 → `trace_data` 01020304, 05060708, 090A0B0C in order; `trace_count` 3→0; `trace_valid` drops after the third pop.
- DEPTH=8: 9 fetches without pops → `trace_count`=8, `overflow`=1, head is the first snapshot. Repeat with full FIFO plus simultaneous pop and push → count stays 8, `overflow` stays 0.
- Exec with opcode 11, P=0x10, M=0x0F, twice consecutively (LOOP_HITS=2) → `halt`=1, `halt_cause`=01. Hit, miss, hit → no halt. P=0x00, M=0xFF counts as a hit.
- `wdog_limit`=5, no loop → `halt` after the 5th fetch, cause 10, `fetch_count`=5. `wdog_limit`=0 → no halt after 70000 fetches; `fetch_count` wraps.
- After halt, further fetch states → no pushes, `fetch_count` frozen, pops still drain. `enable`=0 → nothing captured.
- Assert `reset` low mid-run with FIFO at 4 and halt set → all outputs 0 asynchronously; after release, the next fetch produces `trace_count`=1.
